// File: rtl/clic_pkg.sv
// Shared CLIC constants: trigger encodings, byte-lane indices of a
// per-channel register word, and CPU privilege-mode codes.
package clic_pkg;

  // Trigger encodings held in ATTR.trig. trig[0] = 0 means level.
  localparam logic [1:0] TRIG_LEVEL = 2'b00;
  localparam logic [1:0] TRIG_POS   = 2'b01;
  localparam logic [1:0] TRIG_NEG   = 2'b11;

  // Byte lanes of the per-channel register word (also byte_sel bit index).
  localparam int BSEL_IP   = 0;
  localparam int BSEL_IE   = 1;
  localparam int BSEL_ATTR = 2;
  localparam int BSEL_CTL  = 3;

  // Privilege-mode codes on cpu_clic_mode.
  localparam logic [1:0] CPU_MODE_M = 2'b11;
  localparam logic [1:0] CPU_MODE_U = 2'b00;

endpackage

// File: rtl/clic_kid_bank_if.sv
// Bus-side register access port of the CLIC interrupt bank.
//
// Handshake: busif_xx_write_vld is a single-cycle strobe with no ready;
// the write described by id/byte_sel/wdata is committed on the rising
// clock edge where the strobe is high. kid_busif_rdata is combinational
// from busif_kid_id and is valid in the same cycle the ID is presented.
interface clic_kid_bank_if #(
  parameter int ID_W = 4
);
  logic            busif_xx_write_vld;
  logic [ID_W-1:0] busif_kid_id;
  logic [3:0]      busif_kid_byte_sel;
  logic [31:0]     busif_kid_wdata;
  logic [31:0]     kid_busif_rdata;

  // Bus interface unit side.
  modport master (
    output busif_xx_write_vld,
    output busif_kid_id,
    output busif_kid_byte_sel,
    output busif_kid_wdata,
    input  kid_busif_rdata
  );

  // Interrupt bank side.
  modport slave (
    input  busif_xx_write_vld,
    input  busif_kid_id,
    input  busif_kid_byte_sel,
    input  busif_kid_wdata,
    output kid_busif_rdata
  );
endinterface

// File: rtl/clic_kid_arb.sv
// Combinational max-priority selection over all candidate channels.
// Ties resolve to the lowest channel ID; with no candidate every output is 0.
module clic_kid_arb #(
  parameter int NUM_INT    = 16,
  parameter int ID_W       = 4,
  parameter int INTCTLBITS = 3
) (
  input  logic [NUM_INT-1:0]                 cand,
  input  logic [NUM_INT-1:0][INTCTLBITS-1:0] prio,
  output logic                               win_vld,
  output logic [ID_W-1:0]                    win_id,
  output logic [INTCTLBITS-1:0]              win_prio
);

  // Ascending scan; strict '>' keeps the earlier (lower) ID on equal priority.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (cand[i] && (!win_vld || (prio[i] > win_prio))) begin
        win_vld  = 1'b1;
        win_id   = ID_W'(i);
        win_prio = prio[i];
      end
    end
  end

endmodule

// File: rtl/clic_kid_bank.sv
// Multi-channel CLIC interrupt-pending bank: per-channel IP/IE/ATTR/CTL
// state, edge/level trigger detection and a registered priority arbiter.
// Optional macro CLIC_KID_INPUT_SYNC_EN inserts a 2-flop synchronizer
// ahead of the sample flop on every int_src bit.
module clic_kid_bank
  import clic_pkg::*;
#(
  parameter int NUM_INT    = 16,
  parameter int ID_W       = 4,
  parameter int INTCTLBITS = 3
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic [1:0]            cpu_clic_mode,
  input  logic [NUM_INT-1:0]    int_src,
  clic_kid_bank_if.slave        bus,
  input  logic [INTCTLBITS-1:0] ctrl_kid_thresh,
  input  logic                  ctrl_kid_ack_vld,
  input  logic [ID_W-1:0]       ctrl_kid_ack_id,
  output logic                  kid_arb_req_vld,
  output logic [ID_W-1:0]       kid_arb_req_id,
  output logic [INTCTLBITS-1:0] kid_arb_req_prio,
  output logic                  kid_arb_req_hv
);

  logic [NUM_INT-1:0]                 smp_in, smp, smp_d;
  logic                               arm_q, edge_arm;
  logic [NUM_INT-1:0]                 ip, ie, shv;
  logic [NUM_INT-1:0][1:0]            trig;
  logic [NUM_INT-1:0][INTCTLBITS-1:0] prio;
  logic [NUM_INT-1:0]                 edge_hit, wsel, ack_hit, cand;
  logic                               mode_m, id_ok, wr_ok;
  logic                               win_vld;
  logic [ID_W-1:0]                    win_id;
  logic [INTCTLBITS-1:0]              win_prio;
  logic [7:0]                         ctl_byte;
  logic                               unused_wdata;

  assign unused_wdata = ^bus.busif_kid_wdata;

`ifdef CLIC_KID_INPUT_SYNC_EN
  logic [NUM_INT-1:0] sync_q1, sync_q2;

  // Two-stage synchronizer for asynchronous interrupt lines.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= int_src;
      sync_q2 <= sync_q1;
    end
  end

  assign smp_in = sync_q2;
`else
  assign smp_in = int_src;
`endif

  // Sample flop plus delayed copy; edge detection stays disarmed for the
  // first cycle after reset so stale reset values never look like an edge.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      smp      <= '0;
      smp_d    <= '0;
      arm_q    <= 1'b0;
      edge_arm <= 1'b0;
    end else begin
      smp      <= smp_in;
      smp_d    <= smp;
      arm_q    <= 1'b1;
      edge_arm <= arm_q;
    end
  end

  assign mode_m = (cpu_clic_mode == CPU_MODE_M);
  assign id_ok  = (32'(bus.busif_kid_id) < 32'(NUM_INT));
  assign wr_ok  = bus.busif_xx_write_vld & mode_m & id_ok;

  // Per-channel decode: bus write select, ack match, edge hit, candidacy.
  always_comb begin
    wsel     = '0;
    ack_hit  = '0;
    edge_hit = '0;
    cand     = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      wsel[i]    = wr_ok && (bus.busif_kid_id == ID_W'(i));
      ack_hit[i] = ctrl_kid_ack_vld && (ctrl_kid_ack_id == ID_W'(i));
      if (edge_arm) begin
        if (trig[i] == TRIG_POS)      edge_hit[i] = smp[i] & ~smp_d[i];
        else if (trig[i] == TRIG_NEG) edge_hit[i] = ~smp[i] & smp_d[i];
      end
      cand[i] = ie[i] & ip[i] & (prio[i] > ctrl_kid_thresh);
    end
  end

  // Channel registers; in edge mode IP priority is write > edge > ack.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ip   <= '0;
      ie   <= '0;
      shv  <= '0;
      trig <= '0;
      prio <= '0;
    end else begin
      for (int i = 0; i < NUM_INT; i++) begin
        if (wsel[i] && bus.busif_kid_byte_sel[BSEL_IE]) begin
          ie[i] <= bus.busif_kid_wdata[8];
        end
        if (wsel[i] && bus.busif_kid_byte_sel[BSEL_ATTR]) begin
          trig[i] <= bus.busif_kid_wdata[18:17];
          shv[i]  <= bus.busif_kid_wdata[16];
        end
        if (wsel[i] && bus.busif_kid_byte_sel[BSEL_CTL]) begin
          prio[i] <= bus.busif_kid_wdata[31 -: INTCTLBITS];
        end
        if (trig[i][0] == TRIG_LEVEL[0]) begin
          ip[i] <= smp[i];
        end else if (wsel[i] && bus.busif_kid_byte_sel[BSEL_IP]) begin
          ip[i] <= bus.busif_kid_wdata[0];
        end else if (edge_hit[i]) begin
          ip[i] <= 1'b1;
        end else if (ack_hit[i]) begin
          ip[i] <= 1'b0;
        end
      end
    end
  end

  // Combinational readback; unimplemented CTL bits read as ones.
  always_comb begin
    ctl_byte = 8'hFF;
    ctl_byte[7 -: INTCTLBITS] = prio[bus.busif_kid_id];
    bus.kid_busif_rdata = '0;
    if (mode_m && id_ok) begin
      bus.kid_busif_rdata = {ctl_byte,
                             2'b11, 3'b000, trig[bus.busif_kid_id], shv[bus.busif_kid_id],
                             7'b0, ie[bus.busif_kid_id],
                             7'b0, ip[bus.busif_kid_id]};
    end
  end

  clic_kid_arb #(
    .NUM_INT    (NUM_INT),
    .ID_W       (ID_W),
    .INTCTLBITS (INTCTLBITS)
  ) u_arb (
    .cand     (cand),
    .prio     (prio),
    .win_vld  (win_vld),
    .win_id   (win_id),
    .win_prio (win_prio)
  );

  // Register the arbitration result; hv follows the winner's SHV bit.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      kid_arb_req_vld  <= 1'b0;
      kid_arb_req_id   <= '0;
      kid_arb_req_prio <= '0;
      kid_arb_req_hv   <= 1'b0;
    end else begin
      kid_arb_req_vld  <= win_vld;
      kid_arb_req_id   <= win_id;
      kid_arb_req_prio <= win_prio;
      kid_arb_req_hv   <= win_vld & shv[win_id];
    end
  end

endmodule
